// File: rtl/input_cond_pkg.sv
// Shared defaults, counter-width helper and per-channel event type for input_conditioner.
package input_cond_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LONG_CYCLES     = 32768;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic level;
    logic press;
    logic release_pulse;
    logic long_press;
  } chan_evt_t;

endpackage

// File: rtl/input_cond_channel.sv
// One conditioner channel: reset-to-inactive synchroniser, counter debouncer, edge pulses.
// Long-press detection is compiled in only when LONG_PRESS_EN is defined.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      n_in,
  input  logic      enable,
  output chan_evt_t evt
);

  localparam int            CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   synced;
  logic                   long_press;

  // The chain is active-low; it runs even while the channel is disabled.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], n_in};
    synced    = ~sync_q[SYNC_STAGES-1];
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!enable) begin
      stable_d = 1'b0;
    end else if (synced != stable_q) begin
      if (cnt_q == C_LAST) begin
        stable_d  = synced;
        press_d   = synced;
        release_d = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int            LW     = cnt_width(LONG_CYCLES + 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_press_q, long_press_d;

  // Saturating hold counter; the pulse fires only on the step into saturation.
  always_comb begin
    long_cnt_d   = '0;
    long_press_d = 1'b0;
    if (enable && stable_q) begin
      long_cnt_d   = (long_cnt_q == L_MAX) ? long_cnt_q : long_cnt_q + 1'b1;
      long_press_d = (long_cnt_q == L_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q   <= '0;
      long_press_q <= 1'b0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press = long_press_q;
`else
  assign long_press = 1'b0;
`endif

  assign evt.level         = stable_q;
  assign evt.press         = press_q;
  assign evt.release_pulse = release_q;
  assign evt.long_press    = long_press;

endmodule

// File: rtl/input_conditioner.sv
// N-channel active-low input conditioner: generates one input_cond_channel per pad.
// Define LONG_PRESS_EN to build in the long-press detectors.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] nIn,
  input  logic [CHANNELS-1:0] ChanEnable,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] LongPress
);

  chan_evt_t evt [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    input_cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk   (Clock),
      .rst   (Reset),
      .n_in  (nIn[i]),
      .enable(ChanEnable[i]),
      .evt   (evt[i])
    );

    assign Level[i]     = evt[i].level;
    assign Press[i]     = evt[i].press;
    assign Release[i]   = evt[i].release_pulse;
    assign LongPress[i] = evt[i].long_press;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: stimulus table plus hand sequences, event scoreboard.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int LAT  = SYNC + DEB;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] n_in, en;
  logic [CH-1:0] level, press, release_o, long_o;

  always #5 clk = ~clk;

  input_conditioner #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .Clock     (clk),
    .Reset     (rst),
    .nIn       (n_in),
    .ChanEnable(en),
    .Level     (level),
    .Press     (press),
    .Release   (release_o),
    .LongPress (long_o)
  );

  typedef enum int {K_PRESS, K_RELEASE, K_LONG, K_CLEAR} kind_e;
  typedef struct {
    int    cyc;
    int    ch;
    kind_e kind;
  } evt_t;

  typedef struct {
    string         name;
    logic [CH-1:0] n_in;
    logic [CH-1:0] en;
    int            hold;
    logic [CH-1:0] press_m;
    logic [CH-1:0] release_m;
    logic [CH-1:0] long_m;
  } vec_t;

  evt_t          sb[$];
  vec_t          vecs[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  logic [CH-1:0] exp_level = '0;

  // Expected events are kept sorted by the cycle they must appear on.
  task automatic expect_evt(input int ofs, input int ch, input kind_e k);
    evt_t e;
    int   i;
    e.cyc  = cyc + ofs;
    e.ch   = ch;
    e.kind = k;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic check_one(input string what, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", what, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [CH-1:0] ep, er, el;
    evt_t          e;
    ep = '0;
    er = '0;
    el = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_PRESS:   begin ep[e.ch] = 1'b1; exp_level[e.ch] = 1'b1; end
        K_RELEASE: begin er[e.ch] = 1'b1; exp_level[e.ch] = 1'b0; end
        K_LONG:    el[e.ch] = 1'b1;
        default:   exp_level[e.ch] = 1'b0;
      endcase
    end
    check_one("Level", level, exp_level);
    check_one("Press", press, ep);
    check_one("Release", release_o, er);
    check_one("LongPress", long_o, el);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput();
    end
  endtask

  task automatic add_vec(input string name, input logic [CH-1:0] ni, input logic [CH-1:0] e,
                         input int hold, input logic [CH-1:0] pm, input logic [CH-1:0] rm,
                         input logic [CH-1:0] lm);
    vec_t v;
    v.name = name; v.n_in = ni; v.en = e; v.hold = hold;
    v.press_m = pm; v.release_m = rm; v.long_m = lm;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    n_in = v.n_in;
    en   = v.en;
    for (int c = 0; c < CH; c++) begin
      if (v.press_m[c])   expect_evt(LAT, c, K_PRESS);
      if (v.release_m[c]) expect_evt(LAT, c, K_RELEASE);
`ifdef LONG_PRESS_EN
      if (v.long_m[c])    expect_evt(LAT + LONG, c, K_LONG);
`endif
    end
    tick(v.hold);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    n_in = '1;
    en   = '1;

    add_vec("idle after reset",    4'b1111, 4'b1111, 20, 4'b0000, 4'b0000, 4'b0000);
    add_vec("ch0 press",           4'b1110, 4'b1111,  8, 4'b0001, 4'b0000, 4'b0000);
    add_vec("ch0 release",         4'b1111, 4'b1111, 10, 4'b0000, 4'b0001, 4'b0000);
    add_vec("ch1 3-cycle glitch",  4'b1101, 4'b1111,  3, 4'b0000, 4'b0000, 4'b0000);
    add_vec("ch1 glitch end",      4'b1111, 4'b1111, 10, 4'b0000, 4'b0000, 4'b0000);
    add_vec("ch1 4-cycle pulse",   4'b1101, 4'b1111,  4, 4'b0010, 4'b0000, 4'b0000);
    add_vec("ch1 pulse end",       4'b1111, 4'b1111, 12, 4'b0000, 4'b0010, 4'b0000);
    add_vec("ch2 long hold",       4'b1011, 4'b1111, 25, 4'b0100, 4'b0000, 4'b0100);
    add_vec("ch2 release",         4'b1111, 4'b1111, 20, 4'b0000, 4'b0100, 4'b0000);
    add_vec("ch0+ch3 press",       4'b0110, 4'b1111,  8, 4'b1001, 4'b0000, 4'b0000);
    add_vec("ch0+ch3 release",     4'b1111, 4'b1111, 10, 4'b0000, 4'b1001, 4'b0000);

    tick(3);
    rst = 1'b0;

    foreach (vecs[i]) begin
      $display("[TB] vector: %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    $display("[TB] sequence: reset while ch1 held");
    n_in = 4'b1101;
    expect_evt(LAT, 1, K_PRESS);
    tick(7);
    rst = 1'b1;
    for (int c = 0; c < CH; c++) expect_evt(1, c, K_CLEAR);
    tick(1);
    rst = 1'b0;
    expect_evt(LAT, 1, K_PRESS);
    tick(8);
    n_in = 4'b1111;
    expect_evt(LAT, 1, K_RELEASE);
    tick(10);

    $display("[TB] sequence: ch2 disabled while held, then enabled");
    en   = 4'b1011;
    n_in = 4'b1011;
    tick(12);
    en = 4'b1111;
    expect_evt(DEB, 2, K_PRESS);
    tick(6);
    en = 4'b1011;
    expect_evt(1, 2, K_CLEAR);
    tick(5);
    en = 4'b1111;
    expect_evt(DEB, 2, K_PRESS);
    tick(6);
    n_in = 4'b1111;
    expect_evt(LAT, 2, K_RELEASE);
    tick(10);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d events left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
